// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared state encoding and stream framing constants for the loader
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_LO = 3'd1,
    LEN_HI = 3'd2,
    DATA   = 3'd3,
    DONE   = 3'd4,
    ERR    = 3'd5
  } state_t;

  localparam int LEN_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_word_packer.sv
// rtl/imem_word_packer.sv - assembles little-endian bytes into instruction words
module imem_word_packer
  import imem_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_clr,
  input  logic [7:0]            i_byte,
  input  logic                  i_valid,
  output logic [DATA_WIDTH-1:0] o_word,
  output logic                  o_word_done
);

  logic [1:0]            r_idx;
  logic [DATA_WIDTH-9:0] r_shift;

  // The newest byte lands on top so byte 0 ends up in bits [7:0] after four shifts.
  assign o_word      = {i_byte, r_shift};
  assign o_word_done = i_valid && (r_idx == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_idx   <= '0;
      r_shift <= '0;
    end else if (i_valid) begin
      r_idx   <= r_idx + 2'd1;
      r_shift <= o_word[DATA_WIDTH-1:8];
    end
  end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - loads a length-prefixed byte stream into instruction memory
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [7:0]            byte_i,
  input  logic                  byte_valid_i,
  output logic                  WE,
  output logic [ADDR_WIDTH-1:0] A,
  output logic [DATA_WIDTH-1:0] WD,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic                  cpu_rst_o
);

  localparam int CNT_W = 8 * LEN_BYTES;
  localparam logic [CNT_W:0] DEPTH = {{CNT_W{1'b0}}, 1'b1} << ADDR_WIDTH;

  state_t                r_state;
  state_t                w_next;
  logic [CNT_W-1:0]      r_count;
  logic [CNT_W:0]        r_words;
  logic [CNT_W-1:0]      w_len;
  logic                  w_start;
  logic                  w_accept;
  logic                  w_word_done;
  logic                  w_last;
  logic [DATA_WIDTH-1:0] w_word;

  assign w_start  = start_i && (r_state inside {IDLE, DONE, ERR});
  assign w_accept = byte_valid_i && (r_state == DATA);
  assign w_len    = {byte_i, r_count[7:0]};
  // Writes are at least four cycles apart, so r_words is already up to date here.
  assign w_last   = w_word_done && ((r_words + 1'b1) == {1'b0, r_count});

  imem_word_packer #(.DATA_WIDTH(DATA_WIDTH)) u_packer (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (w_start),
    .i_byte     (byte_i),
    .i_valid    (w_accept),
    .o_word     (w_word),
    .o_word_done(w_word_done)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE, ERR: if (start_i) w_next = LEN_LO;
      LEN_LO:          if (byte_valid_i) w_next = LEN_HI;
      LEN_HI: begin
        if (byte_valid_i) begin
          if (w_len == '0)                 w_next = DONE;
          else if ({1'b0, w_len} > DEPTH)  w_next = ERR;
          else                             w_next = DATA;
        end
      end
      DATA:            if (w_last) w_next = DONE;
      default:         w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      WE      <= 1'b0;
      A       <= '0;
      WD      <= '0;
      r_count <= '0;
      r_words <= '0;
    end else begin
      WE <= w_word_done;
      if (w_word_done) WD <= w_word;
      if (w_start) begin
        A       <= '0;
        r_words <= '0;
      end else if (WE) begin
        A       <= A + 1'b1;
        r_words <= r_words + 1'b1;
      end
      if (r_state == LEN_LO && byte_valid_i) r_count[7:0]  <= byte_i;
      if (r_state == LEN_HI && byte_valid_i) r_count[15:8] <= byte_i;
    end
  end

  assign busy_o    = r_state inside {LEN_LO, LEN_HI, DATA};
  assign done_o    = (r_state == DONE);
  assign err_o     = (r_state == ERR);
  assign cpu_rst_o = (r_state != DONE);

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - scoreboard bench for imem_loader (ADDR_WIDTH 10 and 4 instances)
module tb_imem_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        s10 = 1'b0, bv10 = 1'b0, s4 = 1'b0, bv4 = 1'b0;
  logic [7:0]  b10 = 8'h00, b4 = 8'h00;
  logic        we10, busy10, done10, err10, cpu10;
  logic [9:0]  a10;
  logic [31:0] wd10;
  logic        we4, busy4, done4, err4, cpu4;
  logic [3:0]  a4;
  logic [31:0] wd4;

  imem_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) dut10 (
    .clk(clk), .rst(rst), .start_i(s10), .byte_i(b10), .byte_valid_i(bv10),
    .WE(we10), .A(a10), .WD(wd10), .busy_o(busy10), .done_o(done10),
    .err_o(err10), .cpu_rst_o(cpu10));

  imem_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start_i(s4), .byte_i(b4), .byte_valid_i(bv4),
    .WE(we4), .A(a4), .WD(wd4), .busy_o(busy4), .done_o(done4),
    .err_o(err4), .cpu_rst_o(cpu4));

  typedef struct {
    int          addr;
    logic [31:0] data;
  } exp_t;

  exp_t        q10[$];
  exp_t        q4[$];
  exp_t        e10, e4;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] words[16];

  always @(negedge clk) begin
    if (we10 === 1'b1) begin
      n_cmp++;
      if (q10.size() == 0) begin
        n_bad++;
        $display("FAIL we10_unexpected: got WE at A=%0h WD=%08h, required no write", a10, wd10);
      end else begin
        e10 = q10.pop_front();
        if (a10 !== e10.addr[9:0] || wd10 !== e10.data) begin
          n_bad++;
          $display("FAIL we10_write: got A=%0h WD=%08h, required A=%0h WD=%08h",
                   a10, wd10, e10.addr[9:0], e10.data);
        end
      end
    end
    if (we4 === 1'b1) begin
      n_cmp++;
      if (q4.size() == 0) begin
        n_bad++;
        $display("FAIL we4_unexpected: got WE at A=%0h WD=%08h, required no write", a4, wd4);
      end else begin
        e4 = q4.pop_front();
        if (a4 !== e4.addr[3:0] || wd4 !== e4.data) begin
          n_bad++;
          $display("FAIL we4_write: got A=%0h WD=%08h, required A=%0h WD=%08h",
                   a4, wd4, e4.addr[3:0], e4.data);
        end
      end
    end
  end

  task automatic drive_byte(input bit sel, input logic [7:0] b, input int gap);
    repeat (gap) begin @(posedge clk); #1; end
    if (sel) begin b4 = b; bv4 = 1'b1; end
    else     begin b10 = b; bv10 = 1'b1; end
    @(posedge clk); #1;
    bv4  = 1'b0;
    bv10 = 1'b0;
  endtask

  task automatic pulse_start(input bit sel);
    if (sel) s4 = 1'b1; else s10 = 1'b1;
    @(posedge clk); #1;
    s4  = 1'b0;
    s10 = 1'b0;
  endtask

  task automatic wait_end(input bit sel, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (sel ? (done4 | err4) : (done10 | err10)) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic send_load(input bit sel, input int n, input int gapmax, input int start_at);
    logic [31:0] w;
    for (int i = 0; i < n; i++) begin
      if (sel) q4.push_back('{addr: i, data: words[i]});
      else     q10.push_back('{addr: i, data: words[i]});
    end
    drive_byte(sel, 8'(n), 0);
    drive_byte(sel, 8'(n >> 8), 0);
    for (int i = 0; i < n; i++) begin
      w = words[i];
      for (int k = 0; k < 4; k++) begin
        if (i * 4 + k == start_at) pulse_start(sel);
        drive_byte(sel, w[8*k +: 8], (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0);
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({we10, a10, wd10, busy10, done10, err10, cpu10} !== {1'b0, 10'd0, 32'd0, 4'b0001}) begin
      n_bad++;
      $display("FAIL reset10: got WE=%b A=%0h WD=%08h busy=%b done=%b err=%b cpu_rst=%b, required 0 0 0 0 0 0 1",
               we10, a10, wd10, busy10, done10, err10, cpu10);
    end
    n_cmp++;
    if ({we4, a4, wd4, busy4, done4, err4, cpu4} !== {1'b0, 4'd0, 32'd0, 4'b0001}) begin
      n_bad++;
      $display("FAIL reset4: got WE=%b A=%0h WD=%08h busy=%b done=%b err=%b cpu_rst=%b, required 0 0 0 0 0 0 1",
               we4, a4, wd4, busy4, done4, err4, cpu4);
    end
    rst = 1'b0;
  endtask

  task automatic test_two_word(input int gapmax, input int start_at, input string name);
    bit ok;
    words[0] = 32'h00500013;
    words[1] = 32'h000001B7;
    pulse_start(1'b0);
    n_cmp++;
    if ({busy10, cpu10, done10} !== 3'b110) begin
      n_bad++;
      $display("FAIL %s_busy: got busy=%b cpu_rst=%b done=%b, required 1 1 0", name, busy10, cpu10, done10);
    end
    send_load(1'b0, 2, gapmax, start_at);
    wait_end(1'b0, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL %s_timeout: got no done/err, required done within 100 cycles", name); end
    n_cmp++;
    if ({done10, cpu10, err10, busy10} !== 4'b1000) begin
      n_bad++;
      $display("FAIL %s_done: got done=%b cpu_rst=%b err=%b busy=%b, required 1 0 0 0", name, done10, cpu10, err10, busy10);
    end
    n_cmp++;
    if (q10.size() != 0 || a10 !== 10'd2) begin
      n_bad++;
      $display("FAIL %s_writes: got %0d writes missing, A=%0h, required 0 missing, A=2", name, q10.size(), a10);
      q10.delete();
    end
  endtask

  task automatic test_zero_len();
    bit ok;
    pulse_start(1'b0);
    drive_byte(1'b0, 8'h00, 0);
    drive_byte(1'b0, 8'h00, 0);
    wait_end(1'b0, ok);
    for (int i = 0; i < 4; i++) drive_byte(1'b0, 8'hA5, 0);
    n_cmp++;
    if (!ok || {done10, err10, cpu10, we10} !== 4'b1000) begin
      n_bad++;
      $display("FAIL zero_len: got ok=%b done=%b err=%b cpu_rst=%b WE=%b, required 1 1 0 0 0", ok, done10, err10, cpu10, we10);
    end
  endtask

  task automatic test_oversize();
    bit ok;
    pulse_start(1'b0);
    drive_byte(1'b0, 8'h01, 0);
    drive_byte(1'b0, 8'h04, 0);
    wait_end(1'b0, ok);
    for (int i = 0; i < 4; i++) drive_byte(1'b0, 8'h5A, 0);
    n_cmp++;
    if (!ok || {err10, cpu10, done10, busy10} !== 4'b1100) begin
      n_bad++;
      $display("FAIL oversize: got ok=%b err=%b cpu_rst=%b done=%b busy=%b, required 1 1 1 0 0", ok, err10, cpu10, done10, busy10);
    end
    pulse_start(1'b0);
    n_cmp++;
    if ({err10, busy10} !== 2'b01) begin
      n_bad++;
      $display("FAIL oversize_restart: got err=%b busy=%b, required 0 1", err10, busy10);
    end
    do_reset();
    rst = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    pulse_start(1'b0);
    drive_byte(1'b0, 8'h01, 0);
    drive_byte(1'b0, 8'h00, 0);
    for (int k = 0; k < 3; k++) drive_byte(1'b0, 8'h11 * k, 0);
    rst = 1'b1;
    bv10 = 1'b1;
    b10 = 8'hFF;
    @(posedge clk); #1;
    n_cmp++;
    if ({we10, a10, wd10, busy10, done10, err10, cpu10} !== {1'b0, 10'd0, 32'd0, 4'b0001}) begin
      n_bad++;
      $display("FAIL reset_mid: got WE=%b A=%0h WD=%08h busy=%b done=%b err=%b cpu_rst=%b, required 0 0 0 0 0 0 1",
               we10, a10, wd10, busy10, done10, err10, cpu10);
    end
    rst = 1'b0;
    bv10 = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    words[0] = 32'hDEADBEEF;
    pulse_start(1'b0);
    send_load(1'b0, 1, 0, -1);
    wait_end(1'b0, ok);
    n_cmp++;
    if (!ok || done10 !== 1'b1 || q10.size() != 0) begin
      n_bad++;
      $display("FAIL reset_mid_reload: got ok=%b done=%b missing=%0d, required 1 1 0", ok, done10, q10.size());
      q10.delete();
    end
  endtask

  task automatic test_full_depth();
    bit ok;
    for (int i = 0; i < 16; i++) words[i] = $urandom;
    pulse_start(1'b1);
    send_load(1'b1, 16, 0, -1);
    wait_end(1'b1, ok);
    n_cmp++;
    if (!ok || {done4, cpu4, err4} !== 3'b100 || q4.size() != 0) begin
      n_bad++;
      $display("FAIL full_depth: got ok=%b done=%b cpu_rst=%b err=%b missing=%0d, required 1 1 0 0 0",
               ok, done4, cpu4, err4, q4.size());
      q4.delete();
    end
    repeat (2) begin @(posedge clk); #1; end
    n_cmp++;
    if (a4 !== 4'h0 || we4 !== 1'b0) begin
      n_bad++;
      $display("FAIL full_depth_wrap: got A=%0h WE=%b, required A=0 WE=0", a4, we4);
    end
    pulse_start(1'b1);
    drive_byte(1'b1, 8'h11, 0);
    drive_byte(1'b1, 8'h00, 0);
    wait_end(1'b1, ok);
    n_cmp++;
    if (!ok || {err4, cpu4, done4} !== 3'b110) begin
      n_bad++;
      $display("FAIL depth_plus_one: got ok=%b err=%b cpu_rst=%b done=%b, required 1 1 1 0", ok, err4, cpu4, done4);
    end
  endtask

  initial begin
    test_reset();
    test_two_word(0, -1, "two_word");
    test_zero_len();
    test_two_word(5, 5, "gapped");
    test_oversize();
    test_reset_mid();
    test_full_depth();
    repeat (3) begin @(posedge clk); #1; end
    n_cmp++;
    if (q10.size() != 0 || q4.size() != 0) begin
      n_bad++;
      $display("FAIL leftover: got %0d/%0d pending writes, required 0/0", q10.size(), q4.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning instruction word width; only 32 is supported.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 10, meaning instruction memory word-address width.
REQ-003 Port clk SHALL be input, 1 bit: the single clock; all logic on posedge.
REQ-004 Port rst SHALL be input, 1 bit: reset, synchronous and active-high.
REQ-005 Port start_i SHALL be input, 1 bit: single-cycle request to begin a new load.
REQ-006 Port byte_i SHALL be input, 8 bits: incoming stream byte, e.g. from the UART receiver.
REQ-007 Port byte_valid_i SHALL be input, 1 bit: byte_i is valid this cycle; no backpressure exists.
REQ-008 Port WE SHALL be output, 1 bit: instruction-memory write enable.
REQ-009 Port A SHALL be output, ADDR_WIDTH bits: instruction-memory word address.
REQ-010 Port WD SHALL be output, DATA_WIDTH bits: instruction-memory write data.
REQ-011 Port busy_o SHALL be output, 1 bit: load in progress.
REQ-012 Port done_o SHALL be output, 1 bit: last load completed successfully; level signal.
REQ-013 Port err_o SHALL be output, 1 bit: the header word count exceeded the memory depth; level signal.
REQ-014 Port cpu_rst_o SHALL be output, 1 bit: core hold-in-reset, high in every state except DONE.

Function
REQ-015 The FSM SHALL have states IDLE, LEN_LO, LEN_HI, DATA, DONE and ERR.
REQ-016 In IDLE, DONE or ERR, start_i SHALL move the FSM to LEN_LO and clear the address, byte index, word counter, done_o and err_o.
REQ-017 While the FSM is in LEN_LO, LEN_HI or DATA, start_i SHALL be ignored.
REQ-018 A byte accepted in LEN_LO SHALL become count[7:0], and the FSM SHALL move to LEN_HI.
REQ-019 A byte accepted in LEN_HI SHALL become count[15:8], giving a 16-bit little-endian word count.
REQ-020 On leaving LEN_HI, the next state SHALL be:
- DONE if count == 0;
- ERR if count > 2**ADDR_WIDTH;
- DATA otherwise.
REQ-021 In DATA, bytes SHALL be packed little-endian: byte index 0 into bits [7:0], through index 3 into bits [31:24].
REQ-022 On the cycle after the 4th byte of a word is accepted, the block SHALL drive WE=1 for exactly one cycle, with A = current word address and WD = the assembled word.
REQ-023 After each write, A SHALL increment by 1 and the word counter SHALL increment by 1.
REQ-024 Back-to-back byte_valid_i every cycle SHALL be sustained with no byte dropped.
REQ-025 The write of word N SHALL be able to coincide with acceptance of byte 0 of word N+1.
REQ-026 When the word counter reaches count, the FSM SHALL enter DONE in the same cycle as the final WE pulse.
REQ-027 done_o SHALL go high on entry to DONE; cpu_rst_o SHALL go low on entry to DONE.
REQ-028 When count == 2**ADDR_WIDTH, the last write SHALL use A = all-ones, and A SHALL wrap to 0 afterwards with no further write.
REQ-029 byte_valid_i SHALL be ignored in IDLE, DONE and ERR.
REQ-030 In ERR, err_o=1, cpu_rst_o=1 and WE=0 SHALL hold until start_i or rst.
REQ-031 busy_o SHALL be 1 exactly in LEN_LO, LEN_HI and DATA.
REQ-032 WE SHALL never assert outside the cycle following a completed word.

Reset
REQ-033 rst SHALL, at the clock edge, set the FSM to IDLE.
REQ-034 rst SHALL set these outputs: WE=0, A=0, WD=0, busy_o=0, done_o=0, err_o=0, cpu_rst_o=1.
REQ-035 rst SHALL clear the byte index and word counter.
REQ-036 rst asserted mid-load SHALL abort the load immediately, suppressing any pending WE.
REQ-037 rst SHALL take priority over start_i and byte_valid_i.

Structure
REQ-038 Package imem_loader_pkg SHALL hold the state enum and the constant LEN_BYTES=2.
REQ-039 The package SHALL also hold the constant BYTES_PER_WORD=4.
REQ-040 Byte packing (shift register plus 2-bit index) SHALL be one sub-module, imem_word_packer.
REQ-041 The FSM, address counter and word counter SHALL live in imem_loader.
REQ-042 WE, A and WD SHALL be registered outputs.

Verification
REQ-043 Scenario, two-word load: stimulus start_i, then bytes 02 00 13 00 50 00 B7 01 00 00, valid every cycle. Required response: WE@A=0 with WD=0x00500013, then WE@A=1 with WD=0x000001B7, then done_o=1 and cpu_rst_o=0.
REQ-044 Scenario, zero-length load: stimulus start_i, then bytes 00 00. Required response: DONE with no WE pulse.
REQ-045 Scenario, oversize load (ADDR_WIDTH=10): stimulus header 01 04, i.e. count 1025. Required response: err_o=1, cpu_rst_o=1, no WE; a following start_i clears err_o.
REQ-046 Scenario, reset mid-load: stimulus rst after 3 data bytes. Required response: no WE, all outputs at reset values; a later full load writes from A=0.
REQ-047 Scenario, gapped input: stimulus bytes with 0-5 idle cycles between them. Required response: identical WE/A/WD sequence to the gapless run.
REQ-048 Scenario, full-depth load (ADDR_WIDTH=4): stimulus header 10 00, i.e. 16 words, then 16 words of data. Required response: the final write is at A=0xF, then DONE, then A wraps to 0.
